// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one access per handshake, drives the data
// memory request, waits (with timeout) for completion and returns right-justified,
// zero-filled load data plus size/sign for the downstream sign extender.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_rw,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_size,
  output logic        ld_sign,
  output logic        ld_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_sign_q, ld_sign_d;
  logic        ld_err_q, ld_err_d;
  logic        rw_q, rw_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [7:0]  cnt_q, cnt_d;

  // Access alignment: word on 4, half on 2, byte anywhere, size 3 never.
  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return (off != 2'd0);
      2'd1:    return off[0];
      2'd2:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Byte enables of the addressed lanes (big-endian: offset 0 is bit 3).
  function automatic logic [3:0] lane_be(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd1:    return off[1] ? 4'b0011 : 4'b1100;
      2'd2:    return 4'b1000 >> off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes.
  function automatic logic [31:0] lane_wdata(input logic [31:0] wdata, input logic [1:0] size);
    case (size)
      2'd1:    return {2{wdata[15:0]}};
      2'd2:    return {4{wdata[7:0]}};
      default: return wdata;
    endcase
  endfunction

  // Load data right-justified and zero-filled.
  function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] size);
    case (size)
      2'd1:    return off[1] ? {16'h0, rdata[15:0]} : {16'h0, rdata[31:16]};
      2'd2: begin
        case (off)
          2'd0:    return {24'h0, rdata[31:24]};
          2'd1:    return {24'h0, rdata[23:16]};
          2'd2:    return {24'h0, rdata[15:8]};
          default: return {24'h0, rdata[7:0]};
        endcase
      end
      default: return rdata;
    endcase
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = mem_rw_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;
    ld_size_d   = ld_size_q;
    ld_sign_d   = ld_sign_q;
    ld_err_d    = ld_err_q;
    rw_d        = rw_q;
    off_d       = off_q;
    size_d      = size_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          rw_d        = req_rw;
          off_d       = req_addr[1:0];
          size_d      = req_size;
          sign_d      = req_sign;
          if (misaligned(req_addr[1:0], req_size)) begin
            // No memory traffic; report the error directly.
            state_d    = S_RESP;
            ld_valid_d = 1'b1;
            ld_err_d   = 1'b1;
            ld_data_d  = 32'h0;
            ld_size_d  = req_size;
            ld_sign_d  = req_sign;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_rw_d    = req_rw;
            mem_wdata_d = req_rw ? lane_wdata(req_wdata, req_size) : 32'h0;
            mem_be_d    = lane_be(req_addr[1:0], req_size);
          end
        end
      end

      S_WAIT: begin
        if (mem_ready) begin
          // Completion takes priority over a coincident timeout.
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          mem_be_d   = 4'h0;
          ld_valid_d = 1'b1;
          ld_err_d   = 1'b0;
          ld_data_d  = rw_q ? 32'h0 : align_load(mem_rdata, off_q, size_q);
          ld_size_d  = size_q;
          ld_sign_d  = sign_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_C) begin
            state_d    = S_RESP;
            mem_req_d  = 1'b0;
            mem_be_d   = 4'h0;
            ld_valid_d = 1'b1;
            ld_err_d   = 1'b1;
            ld_data_d  = 32'h0;
            ld_size_d  = size_q;
            ld_sign_d  = sign_q;
          end
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        mem_be_d    = 4'h0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_rw_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= 32'h0;
      ld_size_q   <= 2'd0;
      ld_sign_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      rw_q        <= 1'b0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      sign_q      <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      ld_size_q   <= ld_size_d;
      ld_sign_q   <= ld_sign_d;
      ld_err_q    <= ld_err_d;
      rw_q        <= rw_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rw    = mem_rw_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign ld_size   = ld_size_q;
  assign ld_sign   = ld_sign_q;
  assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases then random accesses against a
// byte-level reference model of alignment, lanes, latency and timeout.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_req, mem_rw, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        ld_valid, ld_sign, ld_err;
  logic [31:0] ld_data;
  logic [1:0]  ld_size;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sign(req_sign),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_size(ld_size), .ld_sign(ld_sign),
    .ld_err(ld_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One access from the pipeline; memory answers after w non-ready request cycles.
  // Called and returns at a negedge with the unit idle.
  task automatic do_access(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                           input logic sign, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int w, input string tag);
    int off, nb, lat, nreq, n, exp_lat, exp_nreq;
    bit mis, tmo, done;
    logic [31:0] exp_data, exp_wdata;
    logic [3:0]  exp_be;

    off = int'(addr[1:0]);
    nb  = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    mis = (size == 2'd3) || ((off % nb) != 0);
    tmo = !mis && (w >= T);
    exp_lat  = mis ? 1 : (tmo ? T + 1 : w + 2);
    exp_nreq = mis ? 0 : (tmo ? T : w + 1);
    exp_be = 4'h0;
    exp_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k >= off && k < off + nb) begin
        exp_be[3-k] = 1'b1;
        exp_data = (exp_data << 8) | ((rdata >> (8 * (3 - k))) & 32'hFF);
      end
    end
    if (mis || tmo || rw) exp_data = 32'h0;
    exp_wdata = 32'h0;
    for (int k = 0; k < 4; k++)
      exp_wdata = (exp_wdata << 8) | ((wdata >> (8 * ((3 - k) % nb))) & 32'hFF);

    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = size;
    req_sign = sign; req_wdata = wdata;
    tick();
    // Garbage offered while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom; req_rw = 1'($urandom_range(0, 1));
    req_size = 2'($urandom_range(0, 3));
    n = 1; nreq = 0; done = 0; lat = 0;
    while (!done && n <= 20) begin
      if (mem_req) begin
        chk({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, " mem_rw"}, 32'(mem_rw), 32'(rw));
        if (rw) begin
          chk({tag, " mem_be"}, 32'(mem_be), 32'(exp_be));
          chk({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        end
        mem_ready = (nreq == w);
        mem_rdata = (nreq == w) ? rdata : $urandom;
        nreq++;
      end else begin
        mem_ready = 1'b0;
        chk({tag, " be idle"}, 32'(mem_be), 32'd0);
      end
      if (ld_valid) begin
        done = 1; lat = n;
        req_valid = 1'b0;
        chk({tag, " ld_data"}, ld_data, exp_data);
        chk({tag, " ld_err"}, 32'(ld_err), 32'(mis || tmo));
        chk({tag, " ld_size"}, 32'(ld_size), 32'(size));
        chk({tag, " ld_sign"}, 32'(ld_sign), 32'(sign));
        chk({tag, " ready busy"}, 32'(req_ready), 32'd0);
      end else begin
        tick();
        n++;
      end
    end
    chk({tag, " responded"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " mem_req cycles"}, 32'(nreq), 32'(exp_nreq));
    mem_ready = 1'b0;
    req_valid = 1'b0;
    tick();
    chk({tag, " ld_valid pulse"}, 32'(ld_valid), 32'd0);
    chk({tag, " ready after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'd0; req_sign = 1'b0; mem_rdata = 32'h0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst ld_valid", 32'(ld_valid), 32'd0);
    chk("rst ld_data", ld_data, 32'h0);
    chk("rst ld_err", 32'(ld_err), 32'd0);
    reset = 1'b0;
    tick();

    do_access(1'b0, 32'h100, 2'd0, 1'b0, 32'h0, 32'hDEADBEEF, 3, "word_load");
    do_access(1'b0, 32'h103, 2'd2, 1'b1, 32'h0, 32'h112233F4, 0, "byte_load");
    do_access(1'b1, 32'h202, 2'd1, 1'b0, 32'h0000ABCD, 32'h0, 1, "half_store");
    do_access(1'b0, 32'h102, 2'd0, 1'b0, 32'h0, 32'h0, 0, "misaligned_word");
    do_access(1'b0, 32'h104, 2'd3, 1'b0, 32'h0, 32'h0, 0, "size3");
    do_access(1'b0, 32'h108, 2'd0, 1'b0, 32'h0, 32'h12345678, 99, "timeout");
    do_access(1'b0, 32'h10C, 2'd1, 1'b1, 32'h0, 32'hCAFE8001, T - 1, "ready_on_timeout");
    do_access(1'b1, 32'h301, 2'd2, 1'b0, 32'h000000A5, 32'h0, 2, "byte_store");

    // Reset while waiting for memory drops the access.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h300; req_size = 2'd0; req_sign = 1'b0;
    tick();
    req_valid = 1'b0; mem_ready = 1'b0;
    chk("rst_wait mem_req", 32'(mem_req), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_wait mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait req_ready", 32'(req_ready), 32'd1);
    chk("rst_wait ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_wait mem_be", 32'(mem_be), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_wait quiet ld_valid", 32'(ld_valid), 32'd0);
      chk("rst_wait quiet mem_req", 32'(mem_req), 32'd0);
    end
    do_access(1'b0, 32'h304, 2'd0, 1'b0, 32'h0, 32'h0BADF00D, 1, "after_reset");

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd0) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0] = 1'b0;
      end
      do_access(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                $urandom, int'($urandom_range(0, T + 1)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
